// File: rtl/ram_arbiter_2c_pkg.sv
// Shared constants and types for the two-client RAM arbiter.
// Client indices are one bit wide since there are exactly two clients.
package ram_arbiter_2c_pkg;

    localparam int NUM_CLIENTS    = 2;
    localparam int IDX_W          = 1;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 16;

    typedef logic [IDX_W-1:0] client_idx_t;

endpackage

// File: rtl/ram_arbiter_2c_if.sv
// Per-client port bundle: one write channel, one read channel and the read-return tag.
// The client drives the master side; the arbiter sits on the slave side.
interface ram_arbiter_2c_if #(
    parameter int ADDR_WIDTH = ram_arbiter_2c_pkg::DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = ram_arbiter_2c_pkg::DEF_DATA_WIDTH
);

    logic                  wr_valid;
    logic                  wr_ready;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [ADDR_WIDTH-1:0] raddr;
    logic                  rdata_valid;

    modport master (
        output wr_valid, waddr, wdata, rd_valid, raddr,
        input  wr_ready, rd_ready, rdata_valid
    );

    modport slave (
        input  wr_valid, waddr, wdata, rd_valid, raddr,
        output wr_ready, rd_ready, rdata_valid
    );

endinterface

// File: rtl/ram.sv
// Simple dual-port block RAM with a registered read port.
// A read and write to the same address in one cycle returns the old contents.
module ram #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] d,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= d;
        end
        if (re) begin
            q <= mem[raddr];
        end
    end

endmodule

// File: rtl/ram_arbiter_2c_rr_arb2.sv
// Two-way round-robin arbiter with a combinational grant and a registered priority pointer.
// After any grant the pointer moves to the client that lost (or was idle).
module rr_arb2
    import ram_arbiter_2c_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_CLIENTS-1:0] req,
    output logic [NUM_CLIENTS-1:0] gnt,
    output client_idx_t            gnt_idx
);

    client_idx_t prio_q;
    client_idx_t prio_d;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        prio_d  = prio_q;
        if (!rst) begin
            // A lone requester wins outright; a tie goes to the pointer.
            gnt_idx = (req == 2'b11) ? prio_q : client_idx_t'(req[1]);
            if (|req) begin
                gnt    = NUM_CLIENTS'(1) << gnt_idx;
                prio_d = ~gnt_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= '0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/ram_arbiter_2c.sv
// Two-client arbiter in front of one dual-port RAM: independent round-robin write and read channels.
// Read data returns one cycle after grant, tagged to the client that won the read.
module ram_arbiter_2c
    import ram_arbiter_2c_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    ram_arbiter_2c_if.slave       c0,
    ram_arbiter_2c_if.slave       c1,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [NUM_CLIENTS-1:0] wr_gnt;
    logic [NUM_CLIENTS-1:0] rd_gnt;
    client_idx_t            wr_idx;
    client_idx_t            rd_idx;

    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_waddr;
    logic [DATA_WIDTH-1:0] ram_d;
    logic                  ram_re;
    logic [ADDR_WIDTH-1:0] ram_raddr;

    logic        rd_tag_valid_q;
    logic        rd_tag_valid_d;
    client_idx_t rd_tag_q;
    client_idx_t rd_tag_d;

    rr_arb2 u_wr_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({c1.wr_valid, c0.wr_valid}),
        .gnt     (wr_gnt),
        .gnt_idx (wr_idx)
    );

    rr_arb2 u_rd_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({c1.rd_valid, c0.rd_valid}),
        .gnt     (rd_gnt),
        .gnt_idx (rd_idx)
    );

    assign c0.wr_ready = wr_gnt[0];
    assign c1.wr_ready = wr_gnt[1];
    assign c0.rd_ready = rd_gnt[0];
    assign c1.rd_ready = rd_gnt[1];

    always_comb begin
        ram_we    = |wr_gnt;
        ram_waddr = (wr_idx == 1'b1) ? c1.waddr : c0.waddr;
        ram_d     = (wr_idx == 1'b1) ? c1.wdata : c0.wdata;
        ram_re    = |rd_gnt;
        ram_raddr = (rd_idx == 1'b1) ? c1.raddr : c0.raddr;
    end

    always_comb begin
        rd_tag_valid_d = |rd_gnt;
        rd_tag_d       = rd_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_tag_valid_q <= 1'b0;
            rd_tag_q       <= '0;
        end else begin
            rd_tag_valid_q <= rd_tag_valid_d;
            rd_tag_q       <= rd_tag_d;
        end
    end

    // Gating with rst drops a response whose grant happened just before reset rose.
    assign c0.rdata_valid = rd_tag_valid_q && (rd_tag_q == 1'b0) && !rst;
    assign c1.rdata_valid = rd_tag_valid_q && (rd_tag_q == 1'b1) && !rst;

    ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .d     (ram_d),
        .re    (ram_re),
        .raddr (ram_raddr),
        .q     (rdata)
    );

endmodule

// File: tb/tb_ram_arbiter_2c.sv
// Directed bench for ram_arbiter_2c: grants are checked per step, read responses via a scoreboard queue.
// Inputs change on the falling edge; the monitor samples each cycle's outputs shortly after that.
module tb_ram_arbiter_2c;

    localparam int AW = 8;
    localparam int DW = 16;

    typedef struct packed {
        logic          idx;
        logic [DW-1:0] data;
    } sb_entry_t;

    logic          clk;
    logic          rst;
    logic [DW-1:0] rdata;

    int assert_cnt = 0;
    int fail_cnt   = 0;
    sb_entry_t sb_q[$];

    ram_arbiter_2c_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) c0_if ();
    ram_arbiter_2c_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) c1_if ();

    ram_arbiter_2c #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .c0    (c0_if),
        .c1    (c1_if),
        .rdata (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assert_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic driveWr(input bit c, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (c) begin
            c1_if.wr_valid = v; c1_if.waddr = a; c1_if.wdata = d;
        end else begin
            c0_if.wr_valid = v; c0_if.waddr = a; c0_if.wdata = d;
        end
    endtask

    task automatic driveRd(input bit c, input logic v, input logic [AW-1:0] a);
        if (c) begin
            c1_if.rd_valid = v; c1_if.raddr = a;
        end else begin
            c0_if.rd_valid = v; c0_if.raddr = a;
        end
    endtask

    task automatic idleAll();
        driveWr(0, 1'b0, '0, '0);
        driveWr(1, 1'b0, '0, '0);
        driveRd(0, 1'b0, '0);
        driveRd(1, 1'b0, '0);
    endtask

    // Called right after inputs are driven on a falling edge; consumes one cycle.
    task automatic applyStimulus(input string name, input logic [1:0] exp_wr, input logic [1:0] exp_rd,
                                 input logic [DW-1:0] exp_rdata, input bit expect_resp);
        sb_entry_t e;
        #1;
        checkOutput({name, " wr_ready"}, {30'd0, c1_if.wr_ready, c0_if.wr_ready}, {30'd0, exp_wr});
        checkOutput({name, " rd_ready"}, {30'd0, c1_if.rd_ready, c0_if.rd_ready}, {30'd0, exp_rd});
        if (expect_resp && exp_rd != 2'b00) begin
            e.idx  = exp_rd[1];
            e.data = exp_rdata;
            sb_q.push_back(e);
        end
        @(negedge clk);
    endtask

    initial begin : monitor
        sb_entry_t e;
        forever begin
            @(negedge clk);
            #2;
            if (c0_if.rdata_valid === 1'b1 || c1_if.rdata_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checkOutput("unexpected rdata_valid", {30'd0, c1_if.rdata_valid, c0_if.rdata_valid}, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("rdata_valid tag", {30'd0, c1_if.rdata_valid, c0_if.rdata_valid},
                                e.idx ? 32'd2 : 32'd1);
                    checkOutput("rdata value", {16'd0, rdata}, {16'd0, e.data});
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        fail_cnt++;
        $display("[TB] FAIL watchdog timeout actual=running expected=finished");
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

    initial begin : stimulus
        rst = 1'b1;
        idleAll();
        repeat (2) @(negedge clk);

        // Requests during reset must see no grants.
        driveWr(0, 1'b1, 8'h05, 16'h1234); driveRd(1, 1'b1, 8'h05);
        applyStimulus("reset", 2'b00, 2'b00, '0, 0);

        rst = 1'b0;
        idleAll();
        driveWr(0, 1'b1, 8'h05, 16'h1234);
        applyStimulus("T1 write", 2'b01, 2'b00, '0, 0);
        idleAll();
        driveRd(0, 1'b1, 8'h05);
        applyStimulus("T1 read", 2'b00, 2'b01, 16'h1234, 1);
        idleAll();

        // A lone c1 write moves wr_prio back to client 0 before the tie run.
        driveWr(1, 1'b1, 8'h30, 16'h5555);
        applyStimulus("T2 c1 alone", 2'b10, 2'b00, '0, 0);
        driveWr(0, 1'b1, 8'h10, 16'hAAAA);
        driveWr(1, 1'b1, 8'h11, 16'hBBBB);
        applyStimulus("T2 tie0", 2'b01, 2'b00, '0, 0);
        applyStimulus("T2 tie1", 2'b10, 2'b00, '0, 0);
        applyStimulus("T2 tie2", 2'b01, 2'b00, '0, 0);
        applyStimulus("T2 tie3", 2'b10, 2'b00, '0, 0);
        idleAll();
        driveRd(0, 1'b1, 8'h10);
        applyStimulus("T2 rd10", 2'b00, 2'b01, 16'hAAAA, 1);
        idleAll();
        driveRd(1, 1'b1, 8'h11);
        applyStimulus("T2 rd11", 2'b00, 2'b10, 16'hBBBB, 1);
        idleAll();

        driveRd(0, 1'b1, 8'h05);
        driveRd(1, 1'b1, 8'h30);
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) applyStimulus("T3 rd tie c0", 2'b00, 2'b01, 16'h1234, 1);
            else            applyStimulus("T3 rd tie c1", 2'b00, 2'b10, 16'h5555, 1);
        end
        idleAll();

        driveWr(0, 1'b1, 8'h20, 16'h0001);
        applyStimulus("T4 wr old", 2'b01, 2'b00, '0, 0);
        driveWr(0, 1'b1, 8'h20, 16'h0002);
        driveRd(1, 1'b1, 8'h20);
        applyStimulus("T4 rbw", 2'b01, 2'b10, 16'h0001, 1);
        idleAll();
        driveRd(0, 1'b1, 8'h20);
        applyStimulus("T4 rd new", 2'b00, 2'b01, 16'h0002, 1);
        idleAll();

        driveWr(1, 1'b1, 8'h40, 16'h4444);
        driveRd(0, 1'b1, 8'h20);
        applyStimulus("T5 wr+rd", 2'b10, 2'b01, 16'h0002, 1);
        // wr_prio now points at c0, rd_prio at c1.
        driveWr(0, 1'b1, 8'h41, 16'h4141);
        driveWr(1, 1'b1, 8'h42, 16'h4242);
        driveRd(0, 1'b1, 8'h40);
        driveRd(1, 1'b1, 8'h40);
        applyStimulus("T5 indep prio", 2'b01, 2'b10, 16'h4444, 1);
        idleAll();

        driveRd(0, 1'b1, 8'h40);
        applyStimulus("T6 rd before rst", 2'b00, 2'b01, '0, 0);
        rst = 1'b1;
        idleAll();
        applyStimulus("T6 in rst", 2'b00, 2'b00, '0, 0);
        rst = 1'b0;
        driveWr(0, 1'b1, 8'h50, 16'h5050);
        driveWr(1, 1'b1, 8'h51, 16'h5151);
        driveRd(0, 1'b1, 8'h41);
        driveRd(1, 1'b1, 8'h42);
        applyStimulus("T6 post rst tie", 2'b01, 2'b01, 16'h4141, 1);
        idleAll();
        applyStimulus("drain0", 2'b00, 2'b00, '0, 0);
        applyStimulus("drain1", 2'b00, 2'b00, '0, 0);

        checkOutput("scoreboard empty", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/ram_arbiter_2c.md
Name: ram_arbiter_2c

Overview:
Two-client arbiter in front of one simple dual-port block RAM instance (`ram`, 1-cycle registered read).
- Write channel and read channel are arbitrated independently, each round-robin. Per cycle: at most one write and one read reach the RAM.
- Read data returns one cycle after grant, tagged to the granted client.
- Sits between two producers/consumers (e.g. pixel writer and display reader) and a shared BRAM buffer.

Parameters:
ADDR_WIDTH, 8, RAM address width; depth = 1 << ADDR_WIDTH
DATA_WIDTH, 16, RAM word width

Ports:
clk  input  1  single clock; all logic on posedge
rst  input  1  synchronous, active-high reset
c0_wr_valid  input  1  client 0 write request
c0_wr_ready  output  1  client 0 write granted this cycle
c0_waddr  input  ADDR_WIDTH  client 0 write address
c0_wdata  input  DATA_WIDTH  client 0 write data
c0_rd_valid  input  1  client 0 read request
c0_rd_ready  output  1  client 0 read granted this cycle
c0_raddr  input  ADDR_WIDTH  client 0 read address
c0_rdata_valid  output  1  rdata belongs to client 0 this cycle
c1_*  (same 8 ports as c0_*)  client 1
rdata  output  DATA_WIDTH  shared read data (RAM q)

Behaviour:
- Interface: one clock, `clk`; reset `rst` is synchronous and active-high.
- Handshake: a transfer occurs on a cycle where valid && ready.
  - ready is combinational from both valids and the channel's priority pointer.
  - Clients hold valid and payload stable until ready. Valid never depends on ready.
- Write arbiter:
  - Only one client valid: that client is granted.
  - Both valid: the client named by wr_prio is granted.
  - On any grant, wr_prio <= the non-granted client index. No grant: wr_prio holds.
- Write datapath:
  - On grant: RAM we=1, waddr/d muxed from the winner in the same cycle. Write lands at the clock edge.
  - No grant: we=0.
- Read arbiter: identical rules with its own pointer rd_prio. The read pointer is independent of wr_prio.
- Read datapath:
  - On grant: RAM re=1, raddr from the winner.
  - Register rd_tag_valid <= grant_any and rd_tag <= winner.
  - Next cycle: cN_rdata_valid = rd_tag_valid && (rd_tag == N); rdata = RAM q.
  - Latency is exactly 1 cycle from grant to rdata_valid. There is no response backpressure; clients must accept.
- Back-to-back reads: full throughput, one grant per cycle. Alternating clients when both are continuously valid.
- rdata holds the last read value when no read is in flight. It is only meaningful when cN_rdata_valid=1.
- Same address read and written in the same cycle: read returns the OLD contents (read-before-write). New data is visible to reads granted on later cycles.
- Reset values:
  - wr_prio=0, rd_prio=0 (client 0 wins the first tie).
  - rd_tag_valid=0, so both rdata_valid=0.
  - While rst=1: all readies=0, we=0, re=0.
- Reset mid-operation: a read granted the cycle before rst rises produces no rdata_valid. RAM contents are not cleared.
- Starvation bound: a continuously valid client is granted within 2 cycles on each channel.

Decomposition:
- Shared package holds:
  - Constant NUM_CLIENTS=2.
  - Client index width (1).
  - Default ADDR_WIDTH/DATA_WIDTH.
- Sub-module rr_arb2 is instantiated twice (write, read).
  - Inputs: clk, rst, req[1:0].
  - Outputs: gnt[1:0] (one-hot or zero, combinational), gnt_idx.
  - Internal registered prio pointer.
- Storage: existing `ram` module instantiated with ADDR_WIDTH/DATA_WIDTH passed through.

Test Plan:
1. Reset, then c0 writes 0x1234 @0x05 alone -> c0_wr_ready=1 same cycle. A later c0 read @0x05 gives c0_rdata_valid=1 exactly 1 cycle after grant, rdata=0x1234, c1_rdata_valid=0.
2. Both clients hold wr_valid for 4 cycles (c0 @0x10 data 0xAAAA, c1 @0x11 data 0xBBBB) -> grants c0,c1,c0,c1. Readback @0x10=0xAAAA, @0x11=0xBBBB.
3. Both hold rd_valid continuously -> rd grants alternate starting with client 0 after reset. The rdata_valid tag follows one cycle later with correct data per client.
4. Write 0x0001 @0x20, then same cycle c0 writes 0x0002 @0x20 and c1 reads @0x20 -> rdata=0x0001. A read next cycle returns 0x0002.
5. Simultaneous write (c1) and read (c0) grants in one cycle -> both ready=1 the same cycle; wr_prio and rd_prio update independently.
6. Grant a read, assert rst the next cycle -> no rdata_valid on either client. After reset, the pointers are 0 and client 0 wins the first tie.
